// File: rtl/pong_game_ctrl_if.sv
// Control/status bundle between the Pong game controller and the video pipeline.
// master drives the frame tick, keys and collision pulses; slave returns game-flow controls.
interface pong_game_ctrl_if;
  logic       refr_tick;
  logic       right_k;
  logic       left_k;
  logic       hit;
  logic       miss;
  logic [2:0] state;
  logic       ball_rst;
  logic       ball_en;
  logic       paddle_en;
  logic [7:0] score;
  logic [2:0] lives;
  logic       game_over;

  modport master (
    output refr_tick, right_k, left_k, hit, miss,
    input  state, ball_rst, ball_en, paddle_en, score, lives, game_over
  );

  modport slave (
    input  refr_tick, right_k, left_k, hit, miss,
    output state, ball_rst, ball_en, paddle_en, score, lives, game_over
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: sequences idle/serve/play/game-over, keeps BCD score and lives.
module pong_game_ctrl #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned OVER_FRAMES  = 180
) (
  input logic             clk,
  input logic             rstn,
  pong_game_ctrl_if.slave bus
);

  localparam int unsigned TIMER_W = 8;
  localparam int unsigned LIVES_W = 3;
  localparam int unsigned SCORE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_OVER  = 3'd3
  } state_t;

  // {ball_rst, ball_en, paddle_en, game_over}
  typedef logic [3:0] ctl_t;

  state_t               state_q;
  ctl_t                 ctl_q;
  logic [TIMER_W-1:0]   timer_q;
  logic [SCORE_W-1:0]   score_q;
  logic [LIVES_W-1:0]   lives_q;
  logic                 key_q;
  logic                 key_c;
  logic                 start_c;

  localparam logic [TIMER_W-1:0] SERVE_LAST = TIMER_W'(SERVE_FRAMES - 1);
  localparam logic [TIMER_W-1:0] OVER_LAST  = TIMER_W'(OVER_FRAMES - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

  function automatic ctl_t decode(input state_t s);
    case (s)
      ST_SERVE: decode = 4'b1010;
      ST_PLAY:  decode = 4'b0110;
      ST_OVER:  decode = 4'b1001;
      default:  decode = 4'b1000;
    endcase
  endfunction

  // Two-digit BCD increment, 99 wraps to 00.
  function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] s);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = s[7:4];
    ones = s[3:0];
    if (ones == 4'd9) begin
      ones = 4'd0;
      tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      ones = ones + 4'd1;
    end
    bcd_inc = {tens, ones};
  endfunction

  assign key_c   = bus.right_k | bus.left_k;
  assign start_c = key_c & ~key_q;

  // Outputs are loaded alongside each state change so they are registered with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      ctl_q   <= decode(ST_IDLE);
      timer_q <= '0;
      score_q <= '0;
      lives_q <= LIVES_INIT;
      key_q   <= 1'b0;
    end else begin
      key_q <= key_c;
      case (state_q)
        ST_IDLE: begin
          if (start_c) begin
            state_q <= ST_SERVE;
            ctl_q   <= decode(ST_SERVE);
            timer_q <= '0;
            score_q <= '0;
            lives_q <= LIVES_INIT;
          end
        end
        ST_SERVE: begin
          if (bus.refr_tick) begin
            if (timer_q == SERVE_LAST) begin
              state_q <= ST_PLAY;
              ctl_q   <= decode(ST_PLAY);
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + TIMER_W'(1);
            end
          end
        end
        ST_PLAY: begin
          // A miss takes priority and drops any coincident hit.
          if (bus.miss) begin
            lives_q <= lives_q - LIVES_W'(1);
            timer_q <= '0;
            if (lives_q == LIVES_W'(1)) begin
              state_q <= ST_OVER;
              ctl_q   <= decode(ST_OVER);
            end else begin
              state_q <= ST_SERVE;
              ctl_q   <= decode(ST_SERVE);
            end
          end else if (bus.hit) begin
            score_q <= bcd_inc(score_q);
          end
        end
        ST_OVER: begin
          if (bus.refr_tick) begin
            if (timer_q == OVER_LAST) begin
              state_q <= ST_IDLE;
              ctl_q   <= decode(ST_IDLE);
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + TIMER_W'(1);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ctl_q   <= decode(ST_IDLE);
          timer_q <= '0;
        end
      endcase
    end
  end

  assign bus.state     = state_q;
  assign bus.ball_rst  = ctl_q[3];
  assign bus.ball_en   = ctl_q[2];
  assign bus.paddle_en = ctl_q[1];
  assign bus.game_over = ctl_q[0];
  assign bus.score     = score_q;
  assign bus.lives     = lives_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: full game flow, BCD wrap, lives, and async reset.
module tb_pong_game_ctrl;

  logic clk;
  logic rstn;
  int   n_assert;
  int   n_fail;

  pong_game_ctrl_if bus ();

  pong_game_ctrl #(
    .LIVES(3),
    .SERVE_FRAMES(60),
    .OVER_FRAMES(180)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_refr();
    bus.refr_tick = 1'b1;
    tick(1);
    bus.refr_tick = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      pulse_refr();
      tick(3);
    end
  endtask

  task automatic pulse_hit(input int n);
    repeat (n) begin
      bus.hit = 1'b1;
      tick(1);
      bus.hit = 1'b0;
      tick(1);
    end
  endtask

  task automatic pulse_miss();
    bus.miss = 1'b1;
    tick(1);
    bus.miss = 1'b0;
  endtask

  task automatic chk_ctl(input string tag, input logic [2:0] st, input logic br,
                         input logic be, input logic pe, input logic go);
    chk({tag, ".state"},     8'(bus.state),     8'(st));
    chk({tag, ".ball_rst"},  8'(bus.ball_rst),  8'(br));
    chk({tag, ".ball_en"},   8'(bus.ball_en),   8'(be));
    chk({tag, ".paddle_en"}, 8'(bus.paddle_en), 8'(pe));
    chk({tag, ".game_over"}, 8'(bus.game_over), 8'(go));
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rstn          = 1'b0;
    bus.refr_tick = 1'b0;
    bus.right_k   = 1'b0;
    bus.left_k    = 1'b0;
    bus.hit       = 1'b0;
    bus.miss      = 1'b0;

    #12;
    chk_ctl("rst", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst.score", bus.score, 8'h00);
    chk("rst.lives", 8'(bus.lives), 8'd3);
    rstn = 1'b1;
    tick(2);

    frames(5);
    chk_ctl("idle5", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle5.score", bus.score, 8'h00);
    chk("idle5.lives", 8'(bus.lives), 8'd3);

    // Start on a one-cycle right key press.
    bus.right_k = 1'b1;
    tick(1);
    bus.right_k = 1'b0;
    chk_ctl("start", 3'd1, 1'b1, 1'b0, 1'b1, 1'b0);

    pulse_hit(1);
    chk("serve.hit_ignored", bus.score, 8'h00);

    frames(59);
    chk("serve59.state", 8'(bus.state), 8'd1);
    pulse_refr();
    chk_ctl("release", 3'd2, 1'b0, 1'b1, 1'b1, 1'b0);

    pulse_hit(12);
    chk("hit12", bus.score, 8'h12);
    pulse_hit(87);
    chk("hit99", bus.score, 8'h99);
    pulse_hit(1);
    chk("hit100.wrap", bus.score, 8'h00);
    pulse_hit(1);
    chk("hit101", bus.score, 8'h01);

    pulse_miss();
    chk_ctl("miss1", 3'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("miss1.lives", 8'(bus.lives), 8'd2);
    chk("miss1.score", bus.score, 8'h01);

    frames(60);
    chk("release2.state", 8'(bus.state), 8'd2);

    bus.hit  = 1'b1;
    bus.miss = 1'b1;
    tick(1);
    bus.hit  = 1'b0;
    bus.miss = 1'b0;
    chk("both.lives", 8'(bus.lives), 8'd1);
    chk("both.score", bus.score, 8'h01);
    chk("both.state", 8'(bus.state), 8'd1);

    frames(60);
    chk("release3.state", 8'(bus.state), 8'd2);
    pulse_miss();
    chk_ctl("over", 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("over.lives", 8'(bus.lives), 8'd0);

    bus.left_k = 1'b1;
    tick(2);
    bus.left_k = 1'b0;
    pulse_hit(1);
    chk("over.key_ignored", 8'(bus.state), 8'd3);
    chk("over.hit_ignored", bus.score, 8'h01);

    frames(179);
    chk("over179.state", 8'(bus.state), 8'd3);
    pulse_refr();
    chk_ctl("back_idle", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("back_idle.score", bus.score, 8'h01);
    chk("back_idle.lives", 8'(bus.lives), 8'd0);

    // New game via left key reloads score and lives.
    bus.left_k = 1'b1;
    tick(1);
    chk("restart.state", 8'(bus.state), 8'd1);
    chk("restart.score", bus.score, 8'h00);
    chk("restart.lives", 8'(bus.lives), 8'd3);
    tick(3);
    bus.left_k = 1'b0;
    frames(60);
    chk("release4.state", 8'(bus.state), 8'd2);
    pulse_hit(3);
    chk("hit3", bus.score, 8'h03);

    // Asynchronous reset between clock edges.
    #2;
    rstn = 1'b0;
    #1;
    chk_ctl("async_rst", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("async_rst.score", bus.score, 8'h00);
    chk("async_rst.lives", 8'(bus.lives), 8'd3);
    #2;
    rstn = 1'b1;
    tick(3);
    chk_ctl("post_rst", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-flow controller for the Pong video pipeline. It sequences the ball and paddle datapath through idle, serve, play and game-over phases. It counts paddle hits as a BCD score and misses against a life budget. It sits beside the pixel generator and drives the ball/paddle enable and reset controls, plus the score and lives values used by the overlay and display logic. All frame-based timing uses the existing one-clock refresh tick asserted at the start of vertical sync.

## Interface
- LIVES, 3, lives loaded at game start (1..7)
- SERVE_FRAMES, 60, refresh ticks spent in SERVE before the ball is released (1..255)
- OVER_FRAMES, 180, refresh ticks GAME_OVER is held before returning to IDLE (1..255)

- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- refr_tick  in  1  one-clock pulse per frame (pixel_y==481, pixel_x==0)
- right_k  in  1  right key, synchronous level, high = pressed
- left_k  in  1  left key, synchronous level, high = pressed
- hit  in  1  one-clock pulse: ball bounced off paddle
- miss  in  1  one-clock pulse: ball passed the paddle edge
- state  out  3  0=IDLE, 1=SERVE, 2=PLAY, 3=GAME_OVER (4..7 unused)
- ball_rst  out  1  hold ball at serve position and velocity
- ball_en  out  1  ball may move on refr_tick
- paddle_en  out  1  paddle may respond to keys
- score  out  8  two-digit BCD hit count, {tens, ones}
- lives  out  3  remaining lives
- game_over  out  1  high while in GAME_OVER

## Operation
- All outputs are registered. Reset values: state=IDLE, ball_rst=1, ball_en=0, paddle_en=0, score=8'h00, lives=LIVES, game_over=0, frame timer=0, key history=0.
- Start event: rising edge of (right_k | left_k), detected against a one-cycle delayed copy of the OR.
- IDLE: ball_rst=1, ball_en=0, paddle_en=0. On a start event, go to SERVE, load score=0 and lives=LIVES, and clear the timer.
- SERVE: ball_rst=1, ball_en=0, paddle_en=1. The timer increments on each refr_tick. When a refr_tick arrives with timer==SERVE_FRAMES-1, go to PLAY and clear the timer.
- PLAY: ball_rst=0, ball_en=1, paddle_en=1.
  - hit: BCD increment of score. Ones 9 rolls to 0 and carries into tens. 99 wraps to 00.
  - miss: lives decrements.
    - If lives was 1: lives becomes 0 and the state goes to GAME_OVER.
    - Otherwise the state goes to SERVE with the timer cleared.
- GAME_OVER: ball_rst=1, ball_en=0, paddle_en=0, game_over=1. Score and lives are held. The timer counts refr_ticks; at OVER_FRAMES-1 the state goes to IDLE. Start events are ignored in this state.
- hit and miss are ignored outside PLAY.
- Key edges are ignored outside IDLE.
- Simultaneous hit and miss in PLAY: miss wins and the hit is discarded.
- Timer width is 8 bits; it is cleared on every state entry.
- score and lives keep their values through IDLE until the next start event, so the final score stays displayed.
- Reset asserted mid-game: all registers go immediately to their reset values, asynchronously.

## Timing
- Every state transition takes effect on the clock edge that samples the triggering pulse. The new state and its outputs are visible the next cycle.
- Start latency: key rises in cycle N → edge detected in N → state=SERVE in N+1.
- Serve release: ball_en rises one cycle after the SERVE_FRAMES-th refr_tick counted in SERVE.
- Score and lives update one cycle after the hit or miss pulse.
- ball_rst and ball_en are never both high.
- Reset deassertion is used as-is; no reset synchronizer is placed in this block.

## Test plan
- Reset, then hold both keys low for 5 frames → state=0, ball_rst=1, ball_en=0, score=00, lives=3.
- Pulse right_k for one cycle in IDLE → state=1 next cycle. After 60 refr_ticks → state=2, ball_en=1, ball_rst=0.
- In PLAY, 12 hit pulses → score=8'h12. Continue to 99 hits total, then 1 more → score=8'h00.
- In PLAY with lives=3, one miss → lives=2, state=1. hit and miss in the same cycle → lives decrements, score unchanged.
- With lives=1, one miss → lives=0, state=3, game_over=1. Key press during GAME_OVER → no effect. After 180 refr_ticks → state=0 with score retained.
- Assert rstn low mid-PLAY, between clock edges → all outputs at reset values with no clock edge needed. Release rstn → state stays IDLE.
